cpu_step_controller: RTL and testbench

- Multicycle sequencer for the single-cycle RISC-V core.
- Drives the `waitt` hold input of the next-PC selector so the PC advances exactly once per retired instruction.
- Runs the req/ack handshakes to instruction memory and data memory, and gates register-file writes to the commit cycle.
- Detects bus timeouts and halts.

---
 rtl/cpu_ctrl_pkg.sv | 18 +
 rtl/cpu_step_controller_wait_timer.sv | 33 +++
 rtl/cpu_step_controller.sv | 131 +++++++++++++
 tb/tb_cpu_step_controller.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and defaults for the multicycle step controller of the RISC-V core.
// The state encoding is also visible to anything that probes the controller.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_START  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_COMMIT = 3'd4,
    ST_HALT   = 3'd5,
    ST_ERROR  = 3'd6
  } state_e;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;
  localparam int unsigned DEFAULT_CNT_W          = 8;

endpackage

// File: rtl/cpu_step_controller_wait_timer.sv
// Bus wait counter shared by the FETCH and MEM handshakes.
// o_last flags the cycle whose increment would reach LIMIT.
module wait_timer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = DEFAULT_CNT_W,
  parameter int unsigned LIMIT = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_last
);

  localparam logic [CNT_W-1:0] LAST_VALUE = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_last = (r_count == LAST_VALUE);

endmodule

// File: rtl/cpu_step_controller.sv
// Multicycle sequencer: holds the PC except in COMMIT, runs the imem/dmem
// req/ack handshakes, gates register-file writes and traps bus timeouts.
module cpu_step_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = DEFAULT_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        halt_req,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        rf_we_en,
  output logic        waitt,
  output logic        bus_error,
  output logic        halted,
  output logic [31:0] retired_count
);

  state_e      r_state;
  state_e      w_next;
  logic        r_store;
  logic        r_ir_we;
  logic [31:0] r_retired_count;
  logic        w_wait_en;
  logic        w_wait_last;

  wait_timer #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (!w_wait_en),
    .i_en   (w_wait_en),
    .o_last (w_wait_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_START;
    end else begin
      r_state <= w_next;
    end
  end

  // An ack on the limit cycle is tested first, so it completes the handshake.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    w_next    = r_state;
    w_wait_en = 1'b0;
    case (r_state)
      ST_START:  w_next = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          w_next = ST_EXEC;
        end else if (w_wait_last) begin
          w_next = ST_ERROR;
        end else begin
          w_wait_en = 1'b1;
        end
      end
      ST_EXEC: begin
        if (halt_req) begin
          w_next = ST_HALT;
        end else if (is_store || is_load) begin
          w_next = ST_MEM;
        end else begin
          w_next = ST_COMMIT;
        end
      end
      ST_MEM: begin
        if (dmem_ack) begin
          w_next = ST_COMMIT;
        end else if (w_wait_last) begin
          w_next = ST_ERROR;
        end else begin
          w_wait_en = 1'b1;
        end
      end
      ST_COMMIT: w_next = ST_FETCH;
      ST_HALT:   w_next = ST_HALT;
      ST_ERROR:  w_next = ST_ERROR;
      default:   w_next = ST_START;
    endcase
  end

  // Store wins over load, so the flag is simply is_store captured in EXEC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_store         <= 1'b0;
      r_ir_we         <= 1'b0;
      r_retired_count <= '0;
    end else begin
      r_ir_we <= (r_state == ST_FETCH) && imem_ack;
      if (r_state == ST_EXEC) begin
        r_store <= is_store;
      end
      if (r_state == ST_COMMIT) begin
        r_retired_count <= r_retired_count + 32'd1;
      end
    end
  end

  assign imem_req      = (r_state == ST_FETCH);
  assign ir_we         = r_ir_we;
  assign dmem_req      = (r_state == ST_MEM);
  assign dmem_we       = (r_state == ST_MEM) && r_store;
  assign rf_we_en      = (r_state == ST_COMMIT);
  assign waitt         = (r_state != ST_COMMIT);
  assign bus_error     = (r_state == ST_ERROR);
  assign halted        = (r_state == ST_HALT);
  assign retired_count = r_retired_count;

`ifndef SYNTHESIS
  a_halt_absorbing: assert property (@(posedge clk) disable iff (reset)
    (r_state == ST_HALT) |=> (r_state == ST_HALT));
  a_error_absorbing: assert property (@(posedge clk) disable iff (reset)
    (r_state == ST_ERROR) |=> (r_state == ST_ERROR));
  a_commit_one_cycle: assert property (@(posedge clk) disable iff (reset)
    (r_state == ST_COMMIT) |=> (r_state == ST_FETCH));
`endif

endmodule

// File: tb/tb_cpu_step_controller.sv
// Scoreboard bench for cpu_step_controller: stimulus pushes the expected retire/halt/error
// event per instruction, a negedge monitor measures what the DUT actually did and compares.
module tb_cpu_step_controller;

  localparam int TIMEOUT = 16;
  localparam int NEVER   = 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic        halt_req = 1'b0;
  logic        imem_req, ir_we, dmem_req, dmem_we, rf_we_en, waitt, bus_error, halted;
  logic [31:0] retired_count;

  cpu_step_controller #(
    .TIMEOUT_CYCLES (TIMEOUT),
    .CNT_W          (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_ack      (imem_ack),
    .dmem_ack      (dmem_ack),
    .is_load       (is_load),
    .is_store      (is_store),
    .halt_req      (halt_req),
    .imem_req      (imem_req),
    .ir_we         (ir_we),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .rf_we_en      (rf_we_en),
    .waitt         (waitt),
    .bus_error     (bus_error),
    .halted        (halted),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_COMMIT = 0, EV_HALT = 1, EV_ERROR = 2} ev_e;
  typedef struct {
    string       tag;
    ev_e         kind;
    int          lat;     // cycles from first FETCH cycle to the event cycle, inclusive
    int          ir_at;   // cycle index (same origin) of the ir_we pulse, 0 if none
    int          mem;     // cycles with dmem_req high
    int          mem_we;  // cycles with dmem_req and dmem_we high
    logic [31:0] cnt;     // retired_count seen in the event cycle
  } ev_t;

  ev_t         exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model_cnt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_compare(input ev_t got);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_unexpected: got event kind %0d with no expectation queued at %0t",
               got.kind, $time);
      return;
    end
    e = exp_q.pop_front();
    check({e.tag, "_kind"},   got.kind,   e.kind);
    check({e.tag, "_lat"},    got.lat,    e.lat);
    check({e.tag, "_ir_at"},  got.ir_at,  e.ir_at);
    check({e.tag, "_mem"},    got.mem,    e.mem);
    check({e.tag, "_mem_we"}, got.mem_we, e.mem_we);
    check({e.tag, "_cnt"},    got.cnt,    e.cnt);
  endtask

  // Monitor: decoupled from stimulus, sees the DUT only through its ports.
  int   mon_counting = 0;
  int   mon_lat = 0, mon_ir_at = 0, mon_mem = 0, mon_mem_we = 0;
  logic mon_prev_err = 1'b0, mon_prev_halt = 1'b0;

  initial begin
    forever begin
      ev_t got;
      @(negedge clk);
      if (reset) begin
        mon_counting = 0;
        mon_prev_err = 1'b0;
        mon_prev_halt = 1'b0;
      end else begin
        check("rf_gate", rf_we_en, !waitt);
        check("dmem_we_qual", dmem_we & ~dmem_req, 1'b0);
        if (imem_req && mon_counting == 0) begin
          mon_counting = 1;
          mon_lat = 0; mon_ir_at = 0; mon_mem = 0; mon_mem_we = 0;
        end
        if (mon_counting != 0) mon_lat++;
        if (ir_we) mon_ir_at = mon_lat;
        if (dmem_req) mon_mem++;
        if (dmem_req && dmem_we) mon_mem_we++;
        got.tag = "mon"; got.lat = mon_lat; got.ir_at = mon_ir_at;
        got.mem = mon_mem; got.mem_we = mon_mem_we; got.cnt = retired_count;
        if (!waitt) begin
          got.kind = EV_COMMIT;
          sb_compare(got);
          mon_counting = 0;
        end else if (bus_error && !mon_prev_err) begin
          got.kind = EV_ERROR;
          sb_compare(got);
          mon_counting = 0;
        end else if (halted && !mon_prev_halt) begin
          got.kind = EV_HALT;
          sb_compare(got);
          mon_counting = 0;
        end
        mon_prev_err  = bus_error;
        mon_prev_halt = halted;
      end
    end
  end

  task automatic apply_reset();
    reset = 1'b1;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    is_load = 1'b0; is_store = 1'b0; halt_req = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_ir_we", ir_we, 1'b0);
    check("rst_dmem_req", dmem_req, 1'b0);
    check("rst_dmem_we", dmem_we, 1'b0);
    check("rst_rf_we_en", rf_we_en, 1'b0);
    check("rst_waitt", waitt, 1'b1);
    check("rst_bus_error", bus_error, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_retired", retired_count, 32'd0);
    model_cnt = '0;
    reset = 1'b0;
  endtask

  // One instruction: imem ack on FETCH cycle index id, dmem ack on MEM cycle index md.
  task automatic do_instr(input string tag, input int id, input int md,
                          input logic ld, input logic st, input logic hl, input logic stray,
                          input ev_e kind, input int lat, input int ir_at,
                          input int mem, input int mem_we);
    ev_t e;
    int  fk = 0;
    int  mk = 0;
    bit  done = 0;
    e.tag = tag; e.kind = kind; e.lat = lat; e.ir_at = ir_at;
    e.mem = mem; e.mem_we = mem_we; e.cnt = model_cnt;
    exp_q.push_back(e);
    if (kind == EV_COMMIT) model_cnt = model_cnt + 32'd1;
    is_load = ld; is_store = st; halt_req = hl;
    imem_ack = 1'b0; dmem_ack = stray;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (!waitt || halted || bus_error) begin
        done = 1;
      end else begin
        imem_ack = imem_req && (fk >= id);
        if (imem_req) fk++;
        dmem_ack = dmem_req ? (mk >= md) : stray;
        if (dmem_req) mk++;
      end
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: no commit/halt/error within 400 cycles", tag);
    end
  endtask

  initial begin
    int bad;

    // Back-to-back ALU instructions with immediate fetch ack: one retire every 3 cycles.
    apply_reset();
    for (int i = 0; i < 10; i++)
      do_instr("alu", 0, 0, 0, 0, 0, 0, EV_COMMIT, 3, 2, 0, 0);
    @(negedge clk);
    check("alu_retired_10", retired_count, 32'd10);

    // Memory traffic, fetch waits, stray acks and the limit-cycle acks.
    apply_reset();
    do_instr("load_d3",     0,  3, 1, 0, 0, 0, EV_COMMIT, 7,  2,  4,  0);
    do_instr("ldst_d1",     0,  1, 1, 1, 0, 0, EV_COMMIT, 5,  2,  2,  2);
    do_instr("store_i2",    2,  0, 0, 1, 0, 0, EV_COMMIT, 6,  4,  1,  1);
    do_instr("alu_stray",   1,  0, 0, 0, 0, 1, EV_COMMIT, 4,  3,  0,  0);
    do_instr("fetch_limit", 15, 0, 0, 0, 0, 0, EV_COMMIT, 18, 17, 0,  0);
    do_instr("mem_limit",   0, 15, 1, 0, 0, 0, EV_COMMIT, 19, 2,  16, 0);
    do_instr("halt",        0,  0, 1, 0, 1, 0, EV_HALT,   3,  2,  0,  0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!(halted && waitt && !imem_req && !dmem_req && !rf_we_en && !bus_error &&
            retired_count == 32'd6)) bad++;
    end
    check("halt_hold_bad_cycles", bad, 0);
    check("halt_retired", retired_count, 32'd6);

    // Fetch timeout: ERROR after 16 unanswered FETCH cycles, then absorbing.
    apply_reset();
    do_instr("fetch_to", NEVER, 0, 0, 0, 0, 0, EV_ERROR, 17, 0, 0, 0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!(bus_error && waitt && !imem_req && !dmem_req && !rf_we_en && !halted)) bad++;
    end
    check("error_hold_bad_cycles", bad, 0);

    // Data timeout on a store-flagged load pair.
    apply_reset();
    do_instr("mem_to", 0, NEVER, 1, 1, 0, 0, EV_ERROR, 19, 2, 16, 16);

    // retired_count wrap.
    apply_reset();
    force dut.r_retired_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_retired_count;
    model_cnt = 32'hFFFF_FFFF;
    do_instr("wrap", 0, 0, 0, 0, 0, 0, EV_COMMIT, 3, 2, 0, 0);
    @(negedge clk);
    check("wrap_to_zero", retired_count, 32'd0);

    // Asynchronous reset pulsed between edges while a store is stalled in MEM.
    apply_reset();
    do_instr("pre_rst_alu", 0, 0, 0, 0, 0, 0, EV_COMMIT, 3, 2, 0, 0);
    is_store = 1'b1;
    bad = 1;
    for (int c = 0; c < 20 && bad != 0; c++) begin
      @(negedge clk);
      imem_ack = imem_req;
      if (dmem_req) bad = 0;
    end
    imem_ack = 1'b0;
    check("pre_rst_dmem_req", dmem_req, 1'b1);
    check("pre_rst_dmem_we", dmem_we, 1'b1);
    check("pre_rst_retired", retired_count, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_dmem_req", dmem_req, 1'b0);
    check("async_rst_dmem_we", dmem_we, 1'b0);
    check("async_rst_waitt", waitt, 1'b1);
    check("async_rst_retired", retired_count, 32'd0);
    apply_reset();
    repeat (2) @(negedge clk);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
